// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from N_REQ requesters into a single UART
// transmitter, holding ownership across multi-byte packets until the last byte.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int LOCK_TIMEOUT = 255,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 busy_err,
    input  logic                 clear_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LC_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int BC_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  owner_inc;
    logic [PTR_W-1:0]  win;
    logic [PTR_W:0]    sum;
    logic              lock;
    logic              last_q;
    logic              found;
    logic              accept;
    logic              busy_tmo;
    logic              lock_idle;
    logic              lock_tmo;
    logic              done;
    logic [7:0]        win_data;
    logic              win_last;
    logic [LC_W-1:0]   lock_cnt;
    logic [BC_W-1:0]   busy_cnt;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v[k] = (PTR_W'(k) == idx);
        end
        return v;
    endfunction

    // Winner selection: the lock owner alone while locked, else first valid from ptr.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        sum   = '0;
        if (lock) begin
            found = req_valid[owner];
            win   = owner;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                sum = {1'b0, ptr} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N_REQ)) begin
                    sum = sum - (PTR_W+1)'(N_REQ);
                end
                if (!found && req_valid[sum[PTR_W-1:0]]) begin
                    found = 1'b1;
                    win   = sum[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        win_data = 8'h00;
        win_last = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (PTR_W'(k) == win) begin
                win_data = req_data[8*k +: 8];
                win_last = req_last[k];
            end
        end
    end

    assign accept    = (state == IDLE) && !tx_busy && found;
    assign owner_inc = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign lock_idle = (state == IDLE) && lock && !req_valid[owner];
    assign lock_tmo  = lock_idle && (lock_cnt == LC_W'(LOCK_TIMEOUT - 1));
    assign busy_tmo  = (state == WAIT_BUSY) && !tx_busy
                       && (busy_cnt == BC_W'(BUSY_TIMEOUT - 1));
    assign done      = (state == WAIT_DONE) && !tx_busy;

    assign req_ready = accept ? onehot(win) : '0;
    assign grant     = ((state != IDLE) || lock) ? onehot(owner) : '0;
    assign tx_start  = (state == LAUNCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (accept) state_nx = LAUNCH;
            LAUNCH:    state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (busy_tmo) begin
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Busy timeout counts from the tx_start cycle, so LAUNCH contributes one tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            lock     <= 1'b0;
            last_q   <= 1'b0;
            tx_data  <= 8'h00;
            busy_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            if (accept) begin
                tx_data  <= win_data;
                last_q   <= win_last;
                owner    <= win;
                busy_cnt <= '0;
                lock_cnt <= '0;
            end
            if ((state == LAUNCH) || ((state == WAIT_BUSY) && !tx_busy)) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
            if (busy_tmo) begin
                lock <= 1'b0;
                ptr  <= owner_inc;
            end
            if (done) begin
                lock_cnt <= '0;
                if (last_q) begin
                    lock <= 1'b0;
                    ptr  <= owner_inc;
                end else begin
                    lock <= 1'b1;
                end
            end
            if (lock_idle) begin
                if (lock_tmo) begin
                    lock     <= 1'b0;
                    ptr      <= owner_inc;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end
        end
    end

    // A new timeout outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_err <= 1'b0;
        end else if (busy_tmo) begin
            busy_err <= 1'b1;
        end else if (clear_err) begin
            busy_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration vector table plus lock, timeout,
// error and reset sequences against a simple transmitter/requester model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           busy_err;
    logic           clear_err;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(255), .BUSY_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .busy_err(busy_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] qd [N][8];
    logic       ql [N][8];
    int         qh [N];
    int         qt [N];

    logic [N-1:0] s_ready, s_grant;
    logic         s_start, s_err;
    logic [7:0]   s_data;
    logic [7:0]   iss_data [16];
    logic [N-1:0] iss_grant [16];
    int           n_iss;
    int           bcnt;
    bit           model_on;
    logic         m_prev_ready = 1'b0;

    typedef struct {
        logic [N-1:0] valid;
        logic [7:0]   base;
        logic [N-1:0] exp_ready;
        logic [7:0]   exp_data;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        qd[i][qt[i]] = d;
        ql[i][qt[i]] = l;
        qt[i]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (qh[i] < qt[i]);
            req_data[8*i +: 8] = (qh[i] < qt[i]) ? qd[i][qh[i]] : 8'h00;
            req_last[i]        = (qh[i] < qt[i]) ? ql[i][qh[i]] : 1'b0;
        end
    endtask

    // Sample mid-cycle, then advance one clock and update requester/transmitter models.
    task automatic tick();
        @(negedge clk);
        s_ready = req_ready;
        s_grant = grant;
        s_start = tx_start;
        s_data  = tx_data;
        s_err   = busy_err;
        if (s_start && n_iss < 16) begin
            iss_data[n_iss]  = s_data;
            iss_grant[n_iss] = s_grant;
            n_iss++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_ready[i] && qh[i] < qt[i]) qh[i]++;
        end
        apply_src();
        if (model_on) begin
            if (s_start) bcnt = 10;
            else if (bcnt > 0) bcnt--;
            tx_busy = (bcnt != 0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bcnt != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, bcnt, 0);
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_prev_ready = 1'b0;
        end else begin
            checks++;
            if (!$onehot0(req_ready)) begin
                errors++;
                $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
            end
            checks++;
            if (tx_start && tx_busy) begin
                errors++;
                $display("FAIL start_while_busy: got tx_start=1 tx_busy=1 expected no start");
            end
            checks++;
            if (tx_start != m_prev_ready) begin
                errors++;
                $display("FAIL start_latency: got tx_start=%b expected %b", tx_start, m_prev_ready);
            end
            m_prev_ready = |req_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   exp_d [5];
        logic [N-1:0] exp_g [5];
        int           n;
        int           bad;

        vecs[0]  = '{4'b1111, 8'h10, 4'b0001, 8'h10};
        vecs[1]  = '{4'b1111, 8'h20, 4'b0010, 8'h21};
        vecs[2]  = '{4'b1111, 8'h30, 4'b0100, 8'h32};
        vecs[3]  = '{4'b1111, 8'h40, 4'b1000, 8'h43};
        vecs[4]  = '{4'b1111, 8'h50, 4'b0001, 8'h50};
        vecs[5]  = '{4'b0001, 8'h60, 4'b0001, 8'h60};
        vecs[6]  = '{4'b1001, 8'h70, 4'b1000, 8'h73};
        vecs[7]  = '{4'b0110, 8'h80, 4'b0010, 8'h81};
        vecs[8]  = '{4'b0110, 8'h90, 4'b0100, 8'h92};
        vecs[9]  = '{4'b0011, 8'hA0, 4'b0001, 8'hA0};
        vecs[10] = '{4'b0000, 8'hB0, 4'b0000, 8'h00};

        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; clear_err = 1'b0;
        model_on = 1'b1; bcnt = 0; n_iss = 0;
        clear_q();

        #2 rst = 1'b1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_err", busy_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Arbitration table: rotating priority with wrap-around.
        for (int e = 0; e < 11; e++) begin
            for (int i = 0; i < N; i++) begin
                if (vecs[e].valid[i]) push(i, vecs[e].base + 8'(i), 1'b1);
            end
            apply_src();
            tick();
            chk("grant_idle", s_grant, 0);
            chk("ready", s_ready, vecs[e].exp_ready);
            clear_q();
            apply_src();
            if (vecs[e].exp_ready != 0) begin
                tick();
                chk("start", s_start, 1);
                chk("tx_data", s_data, vecs[e].exp_data);
                chk("grant", s_grant, vecs[e].exp_ready);
                wait_idle("tbl_idle");
            end
        end

        // Three-byte packet from req1 holds the lock against req0/req2.
        n_iss = 0;
        push(0, 8'hA0, 1'b1);
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b0);
        push(1, 8'hB3, 1'b1);
        push(2, 8'hC2, 1'b1);
        apply_src();
        n = 0;
        while (n_iss < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("pkt_count", n_iss, 5);
        exp_d[0] = 8'hB1; exp_d[1] = 8'hB2; exp_d[2] = 8'hB3; exp_d[3] = 8'hC2; exp_d[4] = 8'hA0;
        exp_g[0] = 4'b0010; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010;
        exp_g[3] = 4'b0100; exp_g[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            chk("pkt_data", iss_data[k], exp_d[k]);
            chk("pkt_grant", iss_grant[k], exp_g[k]);
        end
        wait_idle("pkt_idle");

        // Lock released by idle timeout; waiting req0 served in the release cycle.
        push(3, 8'hD3, 1'b0);
        push(0, 8'hE0, 1'b1);
        apply_src();
        tick();
        chk("lk_ready", s_ready, 4'b1000);
        tick();
        chk("lk_start_data", s_data, 8'hD3);
        wait_idle("lk_idle");
        bad = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (s_grant != 4'b1000 || s_ready != 4'b0000) bad++;
        end
        chk("lk_hold", bad, 0);
        tick();
        chk("lk_release_grant", s_grant, 0);
        chk("lk_release_ready", s_ready, 4'b0001);
        clear_q();
        apply_src();
        tick();
        chk("lk_next_data", s_data, 8'hE0);
        chk("lk_next_grant", s_grant, 4'b0001);
        wait_idle("lk_next_idle");

        // Transmitter never goes busy: error after four cycles, clear, then set-wins.
        model_on = 1'b0;
        tx_busy = 1'b0;
        push(1, 8'h5A, 1'b1);
        apply_src();
        tick();
        chk("be_ready", s_ready, 4'b0010);
        clear_q();
        apply_src();
        tick();
        chk("be_start", s_start, 1);
        tick();
        tick();
        tick();
        chk("be_err_early", s_err, 0);
        tick();
        chk("be_err_set", s_err, 1);
        chk("be_grant_idle", s_grant, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tick();
        chk("be_err_cleared", s_err, 0);
        push(2, 8'h6B, 1'b1);
        apply_src();
        tick();
        chk("be2_ready", s_ready, 4'b0100);
        clear_q();
        apply_src();
        tick();
        chk("be2_start", s_start, 1);
        tick();
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("be2_err_before", s_err, 0);
        tick();
        chk("be2_set_wins", s_err, 1);

        // Reset during WAIT_DONE abandons the byte; arbitration restarts from req0.
        model_on = 1'b1;
        bcnt = 0;
        push(1, 8'h77, 1'b0);
        apply_src();
        tick();
        chk("rs_ready", s_ready, 4'b0010);
        clear_q();
        apply_src();
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rs_start", tx_start, 0);
        chk("rs_ready0", req_ready, 0);
        chk("rs_grant", grant, 0);
        chk("rs_err", busy_err, 0);
        chk("rs_data", tx_data, 0);
        bcnt = 0;
        tx_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        n_iss = 0;
        push(1, 8'h88, 1'b1);
        push(3, 8'h99, 1'b1);
        apply_src();
        tick();
        chk("rs_grant_idle", s_grant, 0);
        chk("rs_ptr0_ready", s_ready, 4'b0010);
        clear_q();
        apply_src();
        tick();
        chk("rs_new_data", s_data, 8'h88);
        wait_idle("rs_idle");
        chk("rs_no_reissue", n_iss, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter LOCK_TIMEOUT, default 255, idle cycles after which a packet lock is forcibly released.
REQ-003 Parameter BUSY_TIMEOUT, default 4, cycles allowed between tx_start and tx_busy rising.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester byte-valid.
REQ-007 req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-008 req_last  in  N_REQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-009 req_ready  out  N_REQ  per-requester accept strobe; a byte transfers when valid and ready are both high.
REQ-010 grant  out  N_REQ  one-hot current owner; all-zero when no owner.
REQ-011 tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-012 tx_data  out  8  registered byte to the transmitter; stable from tx_start until return to IDLE.
REQ-013 tx_busy  in  1  transmitter busy; high the cycle after a start and low once the stop bit ends.
REQ-014 busy_err  out  1  sticky error; transmitter failed to go busy.
REQ-015 clear_err  in  1  synchronous clear of busy_err.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE accept:
- accept only when tx_busy=0;
- unlocked: winner is the first requester with req_valid=1, searching ptr, ptr+1, ... modulo N_REQ;
- locked: only the lock owner is eligible.
REQ-018 Accept cycle T:
- req_ready[winner]=1 combinationally, all other req_ready bits 0;
- tx_data and last_q latched, owner set, next state LAUNCH.
REQ-019 req_ready SHALL be 0 in every state other than IDLE, and at most one bit SHALL be high in any cycle.
REQ-020 LAUNCH: tx_start=1 for exactly one cycle (T+1), then WAIT_BUSY.
REQ-021 WAIT_BUSY:
- tx_busy=1 -> WAIT_DONE;
- otherwise increment the timeout counter;
- BUSY_TIMEOUT cycles without busy -> busy_err=1, lock cleared, ptr=owner+1, return to IDLE.
REQ-022 WAIT_DONE, on tx_busy=0 -> IDLE:
- last_q=0: lock=1, owner retained;
- last_q=1: lock=0, ptr=owner+1 modulo N_REQ.
REQ-023 grant SHALL equal one-hot owner from T+1 until return to IDLE, and SHALL remain asserted in IDLE while locked; otherwise 0.
REQ-024 Locked idle counter:
- counts IDLE cycles while locked and owner's req_valid=0;
- resets on owner accept;
- reaching LOCK_TIMEOUT clears lock, sets ptr=owner+1 and zeroes grant the next cycle.
REQ-025 busy_err simultaneous set and clear_err in the same cycle: set wins.
REQ-026 ptr SHALL wrap from N_REQ-1 to 0.
REQ-027 Byte-to-tx_start latency SHALL be exactly one cycle. No byte SHALL be dropped or duplicated.

Reset
REQ-028 While rst is high, asynchronously:
- state=IDLE, ptr=0, lock=0, owner none;
- all counters 0, tx_data=0;
- tx_start=0, req_ready=0, grant=0, busy_err=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the byte. The byte SHALL NOT be re-issued after reset release.

Verification
REQ-030 Directed bench scenarios:
- All 4 valid, last=1, model busy for 10 cycles -> bytes issued in order req0, req1, req2, req3, req0; tx_start exactly 1 cycle after each ready.
- req1 sends 3 bytes (last on third) while req0 and req2 stay valid -> req1's bytes go back-to-back; req2 is granted next.
- req3 sends a byte with last=0, then drops valid for 255 cycles -> grant clears; a pending req0 is then served.
- tx_busy tied 0 -> busy_err=1 four cycles after tx_start; FSM returns to IDLE; clear_err clears it; clear and new error in the same cycle -> busy_err stays 1.
- rst pulsed during WAIT_DONE -> all outputs 0 immediately; next request starts from ptr=0.
- Check on every cycle: req_ready at most one-hot; tx_start never while tx_busy=1.
